// File: rtl/sram_stream_reader.sv
// sram_stream_reader: streams length words from SRAM at base_addr into a FIFO.
// Ports: start/abort in, busy/done out, SRAM read bus, out_data/valid/ready.
module sram_stream_reader #(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic                abort,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [ADDR_W:0]     length,
  output logic                busy,
  output logic                done,
  output logic [ADDR_W-1:0]   sram_address,
  output logic                sram_chipselect,
  output logic                sram_write,
  output logic [DATA_W/8-1:0] sram_byteenable,
  output logic                sram_clken,
  input  logic [DATA_W-1:0]   sram_readdata,
  output logic [DATA_W-1:0]   out_data,
  output logic                out_valid,
  input  logic                out_ready
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_O = (CW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   rem_q, rem_d;
  logic              infl_q, infl_d;
  logic [PW-1:0]     wr_q, wr_d;
  logic [PW-1:0]     rd_q, rd_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_W-1:0] mem_d [FIFO_DEPTH];

  logic active;
  logic flush;
  logic room;
  logic strobe;
  logic last;
  logic go;
  logic nonempty;
  logic push;
  logic pop;

  assign active   = (state_q == READ) || (state_q == DRAIN);
  assign flush    = abort & active;
  assign go       = (state_q == IDLE) & start & ~abort;
  assign nonempty = (cnt_q != '0);
  // Counting the in-flight word reserves its slot, so the
  // unconditional capture can never overflow the FIFO.
  assign room     = ({1'b0, cnt_q} + {{CW{1'b0}}, infl_q}) < DEPTH_O;
  assign strobe   = (state_q == READ) & room & ~abort;
  assign last     = (rem_q == (ADDR_W+1)'(1));
  assign push     = infl_q & ~flush;
  assign pop      = nonempty & out_ready & ~flush;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (go) begin
          state_d = (length == '0) ? DONE : READ;
        end
      end
      READ: begin
        if (abort) begin
          state_d = IDLE;
        end else if (strobe && last) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (abort) begin
          state_d = IDLE;
        end else if (!nonempty && !infl_q) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    busy            = active;
    done            = (state_q == DONE);
    sram_chipselect = strobe;
    sram_address    = addr_q;
    sram_write      = 1'b0;
    sram_byteenable = '1;
    sram_clken      = 1'b1;
    out_valid       = nonempty;
    out_data        = nonempty ? mem_q[rd_q] : '0;
  end

  always_comb begin
    addr_d = addr_q;
    rem_d  = rem_q;
    if (go) begin
      addr_d = base_addr;
      rem_d  = length;
    end else if (strobe) begin
      addr_d = addr_q + ADDR_W'(1);
      rem_d  = rem_q - (ADDR_W+1)'(1);
    end
    infl_d = strobe;
    mem_d  = mem_q;
    if (push) begin
      mem_d[wr_q] = sram_readdata;
    end
    if (flush) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      wr_d  = wr_q + PW'(push);
      rd_d  = rd_q + PW'(pop);
      cnt_d = cnt_q;
      unique case ({push, pop})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q <= '0;
      rem_q  <= '0;
      infl_q <= 1'b0;
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      addr_q <= addr_d;
      rem_q  <= rem_d;
      infl_q <= infl_d;
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      cnt_q  <= cnt_d;
      mem_q  <= mem_d;
    end
  end

endmodule

// File: tb/tb_sram_stream_reader.sv
// tb_sram_stream_reader: random and directed stimulus against a queue model.
// Drives inputs 1ns after posedge, compares outputs on negedge.
module tb_sram_stream_reader;

  localparam int AW = 10;
  localparam int DW = 32;
  localparam int FD = 4;
  localparam int NW = 1 << AW;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          out_ready = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   length = '0;
  logic          busy, done;
  logic [AW-1:0] sram_address;
  logic          sram_chipselect, sram_write, sram_clken;
  logic [DW/8-1:0] sram_byteenable;
  logic [DW-1:0] sram_readdata, out_data;
  logic          out_valid;

  sram_stream_reader #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .base_addr(base_addr), .length(length), .busy(busy), .done(done),
    .sram_address(sram_address), .sram_chipselect(sram_chipselect),
    .sram_write(sram_write), .sram_byteenable(sram_byteenable),
    .sram_clken(sram_clken), .sram_readdata(sram_readdata),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [NW];
  logic [DW-1:0] rd_data = '0;
  always @(posedge clk) if (sram_chipselect) rd_data <= mem[sram_address];
  assign sram_readdata = rd_data;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] acc_log[$];
  int            strobe_log[$];
  int            s_left = 0;
  logic [AW-1:0] s_addr = '0;
  int            issued = 0;
  int            accepted = 0;
  bit            live = 0;
  int            done_cnt = 0;
  bit            hold_p = 0;
  logic [DW-1:0] hold_v = '0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      if (sram_chipselect) begin
        chk("strobe_allowed", 64'(s_left > 0), 1);
        chk("strobe_addr", 64'(sram_address), 64'(s_addr));
        strobe_log.push_back(int'(sram_address));
        s_addr = s_addr + 1'b1;
        s_left--;
        issued++;
        chk("no_overflow", 64'(issued - accepted <= FD), 1);
      end
      if (out_valid && hold_p) chk("hold_stable", 64'(out_data), 64'(hold_v));
      if (out_valid && out_ready) begin
        chk("data_avail", 64'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          chk("out_data", 64'(out_data), 64'(exp_q.pop_front()));
          acc_log.push_back(out_data);
          accepted++;
        end
      end
      hold_p = out_valid && !out_ready;
      hold_v = out_data;
      if (done) begin
        chk("done_live", 64'(live), 1);
        chk("done_flushed", 64'(exp_q.size()), 0);
        chk("done_strobes", 64'(s_left), 0);
        chk("done_not_busy", 64'(busy), 0);
        done_cnt++;
        live = 0;
      end else if (!live) begin
        chk("idle_quiet", 64'(out_valid), 0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    exp_q.delete();
    s_left = 0;
    live = 0;
    hold_p = 0;
  endtask

  task automatic begin_xfer(logic [AW-1:0] b, int len);
    exp_q.delete();
    for (int i = 0; i < len; i++) exp_q.push_back(mem[(int'(b) + i) & (NW - 1)]);
    s_addr = b;
    s_left = len;
    issued = 0;
    accepted = 0;
    live = 1;
    strobe_log.delete();
    acc_log.delete();
    base_addr = b;
    length = (AW+1)'(len);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(int bound, bit rnd);
    int n = 0;
    while (!done && n < bound) begin
      if (rnd) begin
        out_ready = ($urandom_range(0, 9) < 7);
        start = busy && ($urandom_range(0, 15) == 0);
        base_addr = AW'($urandom);
      end
      tick();
      n++;
    end
    start = 1'b0;
    chk("done_seen", 64'(done), 1);
    tick();
  endtask

  task automatic fill_random();
    for (int i = 0; i < NW; i++) mem[i] = $urandom;
  endtask

  task automatic fill_index();
    for (int i = 0; i < NW; i++) mem[i] = DW'(i);
  endtask

  int d0;
  int n;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    fill_index();
    tick();
    tick();
    chk("rst_busy", 64'(busy), 0);
    chk("rst_done", 64'(done), 0);
    chk("rst_valid", 64'(out_valid), 0);
    chk("rst_cs", 64'(sram_chipselect), 0);
    chk("rst_addr", 64'(sram_address), 0);
    chk("rst_data", 64'(out_data), 0);
    chk("tie_write", 64'(sram_write), 0);
    chk("tie_be", 64'(sram_byteenable), 64'hF);
    chk("tie_clken", 64'(sram_clken), 1);
    reset_n = 1'b1;
    tick();

    // first word two edges after start, then one per cycle
    out_ready = 1'b1;
    d0 = done_cnt;
    begin_xfer(10'h010, 8);
    chk("lat_e0_valid", 64'(out_valid), 0);
    chk("lat_e0_busy", 64'(busy), 1);
    tick();
    chk("lat_e1_valid", 64'(out_valid), 0);
    tick();
    for (int k = 0; k < 8; k++) begin
      chk("seq_valid", 64'(out_valid), 1);
      chk("seq_data", 64'(out_data), 64'(32'h10 + k));
      tick();
    end
    wait_done(20, 0);
    tick();
    chk("seq_done_once", 64'(done_cnt - d0), 1);

    // address wrap at top of SRAM
    fill_random();
    begin_xfer(10'h3FE, 4);
    wait_done(30, 0);
    chk("wrap_nstrobe", 64'(strobe_log.size()), 4);
    chk("wrap_a0", 64'(strobe_log[0]), 64'h3FE);
    chk("wrap_a1", 64'(strobe_log[1]), 64'h3FF);
    chk("wrap_a2", 64'(strobe_log[2]), 64'h000);
    chk("wrap_a3", 64'(strobe_log[3]), 64'h001);
    chk("wrap_d0", 64'(acc_log[0]), 64'(mem[10'h3FE]));
    chk("wrap_d2", 64'(acc_log[2]), 64'(mem[10'h000]));
    chk("wrap_d3", 64'(acc_log[3]), 64'(mem[10'h001]));

    // backpressure stalls strobes at FIFO depth
    out_ready = 1'b0;
    begin_xfer(10'h100, 16);
    repeat (10) tick();
    chk("bp_strobes", 64'(strobe_log.size()), FD);
    chk("bp_valid", 64'(out_valid), 1);
    chk("bp_head", 64'(out_data), 64'(mem[10'h100]));
    out_ready = 1'b1;
    wait_done(60, 0);
    chk("bp_count", 64'(acc_log.size()), 16);
    chk("bp_last", 64'(acc_log[15]), 64'(mem[10'h10F]));

    // zero length
    d0 = done_cnt;
    begin_xfer(10'h055, 0);
    chk("z_done", 64'(done), 1);
    chk("z_busy", 64'(busy), 0);
    tick();
    chk("z_done_drop", 64'(done), 0);
    chk("z_busy2", 64'(busy), 0);
    chk("z_strobes", 64'(strobe_log.size()), 0);
    chk("z_done_cnt", 64'(done_cnt - d0), 1);

    // abort after three accepted words
    fill_index();
    out_ready = 1'b1;
    begin_xfer(10'h020, 10);
    n = 0;
    while (accepted < 3 && n < 20) begin
      tick();
      n++;
    end
    chk("ab_accepted", 64'(accepted), 3);
    chk("ab_third", 64'(acc_log[2]), 64'h22);
    abort = 1'b1;
    out_ready = 1'b0;
    tick();
    abort = 1'b0;
    chk("ab_valid", 64'(out_valid), 0);
    chk("ab_busy", 64'(busy), 0);
    chk("ab_done", 64'(done), 0);
    model_clear();
    d0 = done_cnt;
    repeat (3) tick();
    chk("ab_no_done", 64'(done_cnt - d0), 0);
    out_ready = 1'b1;
    begin_xfer(10'h000, 2);
    wait_done(20, 0);
    chk("ab_next_n", 64'(acc_log.size()), 2);
    chk("ab_next_d0", 64'(acc_log[0]), 64'h0);
    chk("ab_next_d1", 64'(acc_log[1]), 64'h1);

    // reset mid-transfer
    begin_xfer(10'h040, 20);
    repeat (4) tick();
    reset_n = 1'b0;
    #1;
    chk("mr_busy", 64'(busy), 0);
    chk("mr_done", 64'(done), 0);
    chk("mr_valid", 64'(out_valid), 0);
    chk("mr_cs", 64'(sram_chipselect), 0);
    chk("mr_addr", 64'(sram_address), 0);
    chk("mr_data", 64'(out_data), 0);
    model_clear();
    tick();
    tick();
    reset_n = 1'b1;
    d0 = done_cnt;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("mr_quiet_valid", 64'(out_valid), 0);
      chk("mr_quiet_busy", 64'(busy), 0);
    end
    chk("mr_no_done", 64'(done_cnt - d0), 0);

    // randomized transfers with backpressure, stray starts, aborts
    fill_random();
    for (int t = 0; t < 30; t++) begin
      logic [AW-1:0] b;
      int len;
      int ab;
      b = ($urandom_range(0, 3) == 0) ? AW'(NW - $urandom_range(1, 8)) : AW'($urandom);
      len = $urandom_range(0, 40);
      out_ready = ($urandom_range(0, 9) < 7);
      begin_xfer(b, len);
      if (len > 0 && $urandom_range(0, 3) == 0) begin
        ab = $urandom_range(1, len + 3);
        n = 0;
        while (!done && n < ab) begin
          out_ready = ($urandom_range(0, 9) < 7);
          tick();
          n++;
        end
        if (done) begin
          tick();
        end else if (busy) begin
          abort = 1'b1;
          out_ready = 1'b0;
          tick();
          abort = 1'b0;
          chk("rnd_ab_busy", 64'(busy), 0);
          chk("rnd_ab_valid", 64'(out_valid), 0);
          model_clear();
          tick();
        end else begin
          wait_done(40 * len + 50, 1);
        end
      end else begin
        wait_done(40 * len + 50, 1);
        chk("rnd_count", 64'(acc_log.size()), 64'(len));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_stream_reader.md
SRAM_STREAM_READER -- requirements
Module: sram_stream_reader

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, SRAM word-address width.
REQ-002 SHALL have parameter DATA_W, default 32, SRAM/stream data width.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, output buffer depth in words, power of two, minimum 2.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic in this one domain.
REQ-005 SHALL have port reset_n, input, 1, reset; asynchronous assert, active-low.
REQ-006 SHALL have port start, input, 1, one-cycle request to begin a transfer.
REQ-007 SHALL have port abort, input, 1, cancels the transfer in progress.
REQ-008 SHALL have port base_addr, input, ADDR_W, first SRAM word address.
REQ-009 SHALL have port length, input, ADDR_W+1, word count, 0..2^ADDR_W.
REQ-010 SHALL have port busy, output, 1, high while a transfer is active.
REQ-011 SHALL have port done, output, 1, one-cycle completion pulse.
REQ-012 SHALL have port sram_address, output, ADDR_W, SRAM read address.
REQ-013 SHALL have port sram_chipselect, output, 1, SRAM read strobe.
REQ-014 SHALL have port sram_write, output, 1, tied 0.
REQ-015 SHALL have port sram_byteenable, output, DATA_W/8, tied all-ones.
REQ-016 SHALL have port sram_clken, output, 1, tied 1.
REQ-017 SHALL have port sram_readdata, input, DATA_W, SRAM read data, valid exactly 1 cycle after a strobe cycle.
REQ-018 SHALL have port out_data, output, DATA_W, stream data.
REQ-019 SHALL have port out_valid, output, 1, stream valid.
REQ-020 SHALL have port out_ready, input, 1, stream backpressure.

Function
REQ-021 SHALL implement states IDLE, READ, DRAIN, DONE.
REQ-022 SHALL, in IDLE on start=1, latch base_addr and length and enter READ, or enter DONE directly if length=0 with no SRAM strobe.
REQ-023 SHALL ignore start in any state other than IDLE.
REQ-024 SHALL assert sram_chipselect in READ only when fifo_count + in_flight < FIFO_DEPTH, where in_flight is 1 if a strobe was issued the previous cycle, else 0.
REQ-025 SHALL increment the address modulo 2^ADDR_W after each strobe, wrapping 2^ADDR_W-1 to 0.
REQ-026 SHALL capture sram_readdata into the FIFO on the cycle after each strobe, unconditionally; the FIFO SHALL never overflow.
REQ-027 SHALL move from READ to DRAIN on the cycle after the last of length strobes is issued.
REQ-028 SHALL move from DRAIN to DONE once the FIFO is empty and nothing is in flight.
REQ-029 SHALL assert done for exactly one cycle in DONE, then return to IDLE.
REQ-030 SHALL drive busy=1 in READ and DRAIN, 0 in IDLE and DONE.
REQ-031 SHALL present the FIFO head on out_data with out_valid=1 whenever the FIFO is non-empty; a word pops on out_valid & out_ready.
REQ-032 SHALL hold out_data stable while out_valid=1 and out_ready=0.
REQ-033 SHALL handle a simultaneous push and pop in one cycle with fifo_count unchanged.
REQ-034 SHALL sustain 1 word/cycle throughput with out_ready held high, after a first-word latency of 2 cycles from start.
REQ-035 SHALL, on abort in READ or DRAIN, flush the FIFO, discard any in-flight word, and enter IDLE next cycle without pulsing done.
REQ-036 SHALL give abort priority over start in the same cycle.
REQ-037 SHALL emit words in ascending wrapped address order, each exactly once.

Reset
REQ-038 SHALL, while reset_n=0, hold state=IDLE, FIFO empty, in_flight=0, busy=0, done=0, out_valid=0, sram_chipselect=0, sram_address=0, and out_data=0.
REQ-039 SHALL, on reset asserted mid-transfer, abandon it; after release, no stale word SHALL appear and done SHALL not pulse.

Verification
REQ-040 SHALL be checked with: SRAM preloaded mem[i]=i, base=0x010, length=8, out_ready=1 -> out_data 0x10..0x17 on 8 consecutive cycles; first at cycle start+2; done pulses once.
REQ-041 SHALL be checked with: base=0x3FE, length=4 -> addresses 0x3FE, 0x3FF, 0x000, 0x001 and data in that order.
REQ-042 SHALL be checked with: length=16, out_ready=0 for 10 cycles -> exactly FIFO_DEPTH strobes, then a stall, then all 16 words in order with no loss or duplication once ready rises.
REQ-043 SHALL be checked with: length=0 -> no strobe, done one cycle after start, busy never high.
REQ-044 SHALL be checked with: abort after 3 words accepted (length=10) -> out_valid=0 next cycle, no done, and a following start/base=0, length=2 gives 0x00, 0x01.
REQ-045 SHALL be checked with: reset_n pulsed low mid-READ -> all outputs at reset values immediately, IDLE after release.
